// File: rtl/stb_arb_pkg.sv
// -----------------------------------------------------------------------------
// stb_arb_pkg
// Shared definitions for the stb_top micro-instruction arbiter:
//   - FSM state encodings (also visible on the o_state debug port)
//   - instruction width and field offsets as functions of the address widths
//   - stb_inst_t, the instruction layout at the default address widths
// Ports: none (package).
// -----------------------------------------------------------------------------
package stb_arb_pkg;

    localparam logic [1:0] STATE_IDLE      = 2'd0;
    localparam logic [1:0] STATE_ISSUE     = 2'd1;
    localparam logic [1:0] STATE_WAIT_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = STATE_IDLE,
        ST_ISSUE     = STATE_ISSUE,
        ST_WAIT_DONE = STATE_WAIT_DONE
    } arb_state_e;

    // Fixed-width fields; together they make up the 16 non-address bits.
    localparam int SMC_STRB_W  = 6;
    localparam int BYTE_STRB_W = 4;
    localparam int BRST_W      = 2;
    localparam int UR_ID_W     = 4;
    localparam int CTRL_W      = SMC_STRB_W + BYTE_STRB_W + BRST_W + UR_ID_W;

    localparam int DEF_ADDR_WIDTH    = 32;
    localparam int DEF_UR_ADDR_WIDTH = 11;

    function automatic int inst_w(input int addr_w, input int ur_addr_w);
        return CTRL_W + addr_w + ur_addr_w;
    endfunction

    // LSB offsets of each field inside the packed instruction (ur_addr at bit 0).
    function automatic int ur_id_lsb(input int ur_addr_w);
        return ur_addr_w;
    endfunction

    function automatic int gr_base_addr_lsb(input int ur_addr_w);
        return ur_id_lsb(ur_addr_w) + UR_ID_W;
    endfunction

    function automatic int brst_lsb(input int addr_w, input int ur_addr_w);
        return gr_base_addr_lsb(ur_addr_w) + addr_w;
    endfunction

    function automatic int byte_strb_lsb(input int addr_w, input int ur_addr_w);
        return brst_lsb(addr_w, ur_addr_w) + BRST_W;
    endfunction

    function automatic int smc_strb_lsb(input int addr_w, input int ur_addr_w);
        return byte_strb_lsb(addr_w, ur_addr_w) + BYTE_STRB_W;
    endfunction

    // Instruction layout, MSB->LSB, at the default address widths.
    typedef struct packed {
        logic [SMC_STRB_W-1:0]        smc_strb;
        logic [BYTE_STRB_W-1:0]       byte_strb;
        logic [BRST_W-1:0]            brst;      // 00=1, 01=2, 10=4, 11=8 beats
        logic [DEF_ADDR_WIDTH-1:0]    gr_base_addr;
        logic [UR_ID_W-1:0]           ur_id;
        logic [DEF_UR_ADDR_WIDTH-1:0] ur_addr;
    } stb_inst_t;

endpackage

// File: rtl/stb_inst_arb_if.sv
// -----------------------------------------------------------------------------
// stb_inst_arb_if
// Bundles the requester side and the stb_top micro-instruction side of the
// arbiter, plus its debug/status flags.
//   master : the arbiter (drives ready/done, u_* pins and status)
//   slave  : requesters + stb_top (drive valid/inst and d_valid/d_done)
// Signals: i_req_valid, o_req_ready, i_req_inst, o_req_done, o_req_err,
//   o_micro_inst_u_*, i_micro_inst_d_valid, i_micro_inst_d_done,
//   o_state, o_owner, o_err_spurious, o_err_timeout.
// -----------------------------------------------------------------------------
interface stb_inst_arb_if
    import stb_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int UR_ADDR_WIDTH = 11
);
    localparam int INST_W = inst_w(ADDR_WIDTH, UR_ADDR_WIDTH);
    localparam int IDX_W  = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        i_req_valid;
    logic [NUM_REQ-1:0]        o_req_ready;
    logic [NUM_REQ*INST_W-1:0] i_req_inst;
    logic [NUM_REQ-1:0]        o_req_done;
    logic                      o_req_err;

    logic                      o_micro_inst_u_valid;
    logic [SMC_STRB_W-1:0]     o_micro_inst_u_smc_strb;
    logic [BYTE_STRB_W-1:0]    o_micro_inst_u_byte_strb;
    logic [BRST_W-1:0]         o_micro_inst_u_brst;
    logic [ADDR_WIDTH-1:0]     o_micro_inst_u_gr_base_addr;
    logic [UR_ID_W-1:0]        o_micro_inst_u_ur_id;
    logic [UR_ADDR_WIDTH-1:0]  o_micro_inst_u_ur_addr;
    logic                      i_micro_inst_d_valid;
    logic                      i_micro_inst_d_done;

    logic [1:0]                o_state;
    logic [IDX_W-1:0]          o_owner;
    logic                      o_err_spurious;
    logic                      o_err_timeout;

    modport master (
        input  i_req_valid, i_req_inst, i_micro_inst_d_valid, i_micro_inst_d_done,
        output o_req_ready, o_req_done, o_req_err,
               o_micro_inst_u_valid, o_micro_inst_u_smc_strb, o_micro_inst_u_byte_strb,
               o_micro_inst_u_brst, o_micro_inst_u_gr_base_addr, o_micro_inst_u_ur_id,
               o_micro_inst_u_ur_addr,
               o_state, o_owner, o_err_spurious, o_err_timeout
    );

    modport slave (
        output i_req_valid, i_req_inst, i_micro_inst_d_valid, i_micro_inst_d_done,
        input  o_req_ready, o_req_done, o_req_err,
               o_micro_inst_u_valid, o_micro_inst_u_smc_strb, o_micro_inst_u_byte_strb,
               o_micro_inst_u_brst, o_micro_inst_u_gr_base_addr, o_micro_inst_u_ur_id,
               o_micro_inst_u_ur_addr,
               o_state, o_owner, o_err_spurious, o_err_timeout
    );
endinterface

// File: rtl/stb_rr_arb.sv
// -----------------------------------------------------------------------------
// stb_rr_arb
// Combinational round-robin grant: picks the first asserted request at or
// after rr_ptr, wrapping modulo NUM_REQ.
// Ports:
//   req       in  NUM_REQ  request vector
//   rr_ptr    in  IDX_W    highest-priority index (must be < NUM_REQ)
//   grant     out NUM_REQ  one-hot grant (0 when no request)
//   grant_idx out IDX_W    index of the granted request
//   any       out 1        at least one request present
// -----------------------------------------------------------------------------
module stb_rr_arb #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int               k;
    logic [IDX_W-1:0] kk;

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves
        // a value unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        k         = 0;
        kk        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            kk = IDX_W'(k);
            if (!any && req[kk]) begin
                any       = 1'b1;
                grant[kk] = 1'b1;
                grant_idx = kk;
            end
        end
    end

endmodule

// File: rtl/stb_inst_arb.sv
// -----------------------------------------------------------------------------
// stb_inst_arb
// Shares stb_top's single micro-instruction port between NUM_REQ requesters.
// Round-robin grant, one instruction in flight, completion routed back to the
// requester that issued it. IDLE -> ISSUE (u_valid until d_valid) ->
// WAIT_DONE (until d_done) -> IDLE; d_valid and d_done together skip WAIT_DONE.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous reset, active-high
//   bus  stb_inst_arb_if.master: requester handshake, u_*/d_* pins, status
// Optional feature: define STB_ARB_TIMEOUT_EN to enable a WAIT_DONE watchdog
// of TIMEOUT_CYC cycles that completes the instruction with o_req_err=1.
// -----------------------------------------------------------------------------
module stb_inst_arb
    import stb_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int UR_ADDR_WIDTH = 11,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic           clk,
    input  logic           rst,
    stb_inst_arb_if.master bus
);

    localparam int INST_W    = inst_w(ADDR_WIDTH, UR_ADDR_WIDTH);
    localparam int IDX_W     = $clog2(NUM_REQ);
    localparam int UR_ID_LSB = ur_id_lsb(UR_ADDR_WIDTH);
    localparam int ADDR_LSB  = gr_base_addr_lsb(UR_ADDR_WIDTH);
    localparam int BRST_LSB  = brst_lsb(ADDR_WIDTH, UR_ADDR_WIDTH);
    localparam int BYTE_LSB  = byte_strb_lsb(ADDR_WIDTH, UR_ADDR_WIDTH);
    localparam int SMC_LSB   = smc_strb_lsb(ADDR_WIDTH, UR_ADDR_WIDTH);

    // Out-of-range configurations are marked by this block in the hierarchy.
    if (TIMEOUT_CYC < 2 || NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_config
    end

    arb_state_e          state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    owner_q;
    logic [INST_W-1:0]   inst_q;
    logic                u_valid_q;
    logic [NUM_REQ-1:0]  done_q;
    logic                err_spurious_q;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_any;
    logic [IDX_W-1:0]    next_ptr;

    stb_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
        .req       (bus.i_req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Priority moves to the requester after the one that just completed.
    assign next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

`ifdef STB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             req_err_q;
    logic             err_timeout_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            // NOTE: the instruction register is reset as well so the u_* pins
            // read 0 out of reset instead of stale or unknown bits.
            inst_q         <= '0;
            u_valid_q      <= 1'b0;
            done_q         <= '0;
            err_spurious_q <= 1'b0;
`ifdef STB_ARB_TIMEOUT_EN
            wait_cnt_q     <= '0;
            req_err_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout; the defaults below are
            // overridden later in the block when a completion happens.
            done_q <= '0;
`ifdef STB_ARB_TIMEOUT_EN
            req_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_micro_inst_d_done) err_spurious_q <= 1'b1;
                    if (grant_any) begin
                        inst_q    <= bus.i_req_inst[int'(grant_idx)*INST_W +: INST_W];
                        owner_q   <= grant_idx;
                        u_valid_q <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.i_micro_inst_d_valid) begin
                        u_valid_q <= 1'b0;
                        if (bus.i_micro_inst_d_done) begin
                            done_q[owner_q] <= 1'b1;
                            rr_ptr_q        <= next_ptr;
                            state_q         <= ST_IDLE;
                        end else begin
                            state_q <= ST_WAIT_DONE;
`ifdef STB_ARB_TIMEOUT_EN
                            wait_cnt_q <= '0;
`endif
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.i_micro_inst_d_done) begin
                        done_q[owner_q] <= 1'b1;
                        rr_ptr_q        <= next_ptr;
                        state_q         <= ST_IDLE;
`ifdef STB_ARB_TIMEOUT_EN
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        done_q[owner_q] <= 1'b1;
                        req_err_q       <= 1'b1;
                        err_timeout_q   <= 1'b1;
                        rr_ptr_q        <= next_ptr;
                        state_q         <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Ready is the only combinational output: the grant is visible in the same
    // cycle the requester presents, and never while reset is asserted.
    assign bus.o_req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;
    assign bus.o_req_done  = done_q;

    assign bus.o_micro_inst_u_valid        = u_valid_q;
    assign bus.o_micro_inst_u_smc_strb     = inst_q[SMC_LSB   +: SMC_STRB_W];
    assign bus.o_micro_inst_u_byte_strb    = inst_q[BYTE_LSB  +: BYTE_STRB_W];
    assign bus.o_micro_inst_u_brst         = inst_q[BRST_LSB  +: BRST_W];
    assign bus.o_micro_inst_u_gr_base_addr = inst_q[ADDR_LSB  +: ADDR_WIDTH];
    assign bus.o_micro_inst_u_ur_id        = inst_q[UR_ID_LSB +: UR_ID_W];
    assign bus.o_micro_inst_u_ur_addr      = inst_q[0         +: UR_ADDR_WIDTH];

    assign bus.o_state        = state_q;
    assign bus.o_owner        = owner_q;
    assign bus.o_err_spurious = err_spurious_q;

`ifdef STB_ARB_TIMEOUT_EN
    assign bus.o_req_err     = req_err_q;
    assign bus.o_err_timeout = err_timeout_q;
`else
    assign bus.o_req_err     = 1'b0;
    assign bus.o_err_timeout = 1'b0;
`endif

endmodule
